// File: rtl/mult_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler_pkg
// Shared constants for the multiplier scheduler: operand/product widths of the
// shared 8x8 multiplier, its default latency, and a clog2 helper used to size
// ids, counters and pointers.
// -----------------------------------------------------------------------------
package mult_rr_scheduler_pkg;

    localparam int MULT_A_W             = 8;
    localparam int MULT_B_W             = 8;
    localparam int MULT_C_W             = 16;
    localparam int MULT_LATENCY_DEFAULT = 1;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// -----------------------------------------------------------------------------
// mult_result_fifo
// Synchronous first-word-fall-through FIFO holding tagged multiplier results.
// The head entry is visible on pop_data whenever count is non-zero; pop_data
// reads as zero while empty so nothing stale ever leaks out.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset (empties the FIFO)
//   push       write push_data at the next edge
//   push_data  entry to store
//   pop        consume the head entry at the next edge
//   pop_data   current head entry (zero when empty)
//   count      number of stored entries
// -----------------------------------------------------------------------------
module mult_result_fifo
    import mult_rr_scheduler_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 18
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1'b1);
    endfunction

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == '0);
    assign do_pop_s  = pop & ~empty_s;
    // A push into a full FIFO is only accepted when the head leaves that cycle.
    assign do_push_s = push & (~full_s | do_pop_s);
    assign count     = count_r;

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Fall-through head, forced to zero while empty.
    always_comb begin
        pop_data = '0;
        if (!empty_s) begin
            pop_data = mem_r[rd_ptr_r];
        end else begin
            pop_data = '0;
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
// Shares one external registered 8x8 multiplier between N requesters. A
// round-robin arbiter grants at most one operand pair per cycle, gated by a
// credit check so every issued product is guaranteed a result FIFO slot. Each
// issue is tagged with the requester id; the tag travels alongside the
// multiplier pipeline and is paired with mult_C when it emerges, then returned
// in issue order on a single valid/ready response channel.
//
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   req_valid/req_ready               per-requester handshake (ready one-hot)
//   req_A/req_B, req_A_sign/req_B_sign flattened operands and sign selects
//   mult_A/mult_B, mult_*_sign        operands to the shared multiplier
//   mult_HALF_0                       multiplier half mode, always 0
//   mult_C                            registered multiplier product
//   resp_valid/resp_ready             result channel handshake
//   resp_id, resp_C                   requester id and product of the head
//   idle                              nothing in flight and FIFO empty
//   ops_count                         issued operation counter (wraps)
// -----------------------------------------------------------------------------
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int N            = 4,
    parameter int ID_W         = clog2(N),
    parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT,
    parameter int RES_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [MULT_A_W*N-1:0]   req_A,
    input  logic [MULT_B_W*N-1:0]   req_B,
    input  logic [N-1:0]            req_A_sign,
    input  logic [N-1:0]            req_B_sign,
    output logic [MULT_A_W-1:0]     mult_A,
    output logic [MULT_B_W-1:0]     mult_B,
    output logic                    mult_A_sign,
    output logic                    mult_B_sign,
    output logic                    mult_HALF_0,
    input  logic [MULT_C_W-1:0]     mult_C,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [MULT_C_W-1:0]     resp_C,
    output logic                    idle,
    output logic [31:0]             ops_count
);

    localparam int CNT_W  = clog2(RES_DEPTH + 1);
    localparam int OCC_W  = clog2(RES_DEPTH + MULT_LATENCY + 1) + 1;
    localparam int FIFO_W = ID_W + MULT_C_W;

    logic [ID_W-1:0]         ptr_r;
    logic                    run_r;
    logic [31:0]             ops_count_r;
    logic [MULT_LATENCY-1:0] tag_valid_r;
    logic [ID_W-1:0]         tag_id_r [MULT_LATENCY];

    logic [CNT_W-1:0]        fifo_count_s;
    logic [FIFO_W-1:0]       fifo_head_s;
    logic [FIFO_W-1:0]       push_data_s;
    logic                    push_s;
    logic                    pop_s;
    logic [OCC_W-1:0]        in_flight_s;
    logic [OCC_W-1:0]        occupancy_s;
    logic                    issue_ok_s;
    logic [ID_W:0]           cand_s;
    logic                    grant_found_s;
    logic [ID_W-1:0]         grant_id_s;

    assign resp_valid  = (fifo_count_s != '0);
    assign pop_s       = resp_valid & resp_ready;
    assign mult_HALF_0 = 1'b0;
    assign ops_count   = ops_count_r;

    // Count operations currently travelling through the multiplier.
    always_comb begin
        in_flight_s = '0;
        for (int s = 0; s < MULT_LATENCY; s++) begin
            if (tag_valid_r[s]) begin
                in_flight_s = in_flight_s + OCC_W'(1'b1);
            end else begin
                in_flight_s = in_flight_s;
            end
        end
    end

    // Every in-flight op already owns a FIFO slot; a slot freed by this
    // cycle's pop can be handed out immediately, which keeps 1 op/cycle
    // throughput but makes req_ready combinational on resp_ready.
    assign occupancy_s = in_flight_s + OCC_W'(fifo_count_s) - OCC_W'(pop_s);
    assign issue_ok_s  = run_r && (occupancy_s < OCC_W'(RES_DEPTH));

    // Round-robin search: first valid requester at or after ptr, modulo N.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        cand_s        = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (cand_s >= (ID_W+1)'(N)) begin
                cand_s = cand_s - (ID_W+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (issue_ok_s && !grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant and operand steering to the multiplier; all zero when idle.
    always_comb begin
        req_ready   = '0;
        mult_A      = '0;
        mult_B      = '0;
        mult_A_sign = 1'b0;
        mult_B_sign = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_found_s && (grant_id_s == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mult_A       = req_A[i*MULT_A_W +: MULT_A_W];
                mult_B       = req_B[i*MULT_B_W +: MULT_B_W];
                mult_A_sign  = req_A_sign[i];
                mult_B_sign  = req_B_sign[i];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Round-robin pointer, issue counter, and post-reset run enable that keeps
    // req_ready low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r       <= '0;
            run_r       <= 1'b0;
            ops_count_r <= 32'd0;
        end else begin
            run_r <= 1'b1;
            if (grant_found_s) begin
                ptr_r       <= (grant_id_s == ID_W'(N - 1)) ? '0 : grant_id_s + ID_W'(1'b1);
                ops_count_r <= ops_count_r + 32'd1;
            end
        end
    end

    // Tag pipeline mirrors the multiplier latency so the last stage lines up
    // with the product; clearing it on reset is what discards stale mult_C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_r <= '0;
            for (int s = 0; s < MULT_LATENCY; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_valid_r[0] <= grant_found_s;
            tag_id_r[0]    <= grant_id_s;
            for (int s = 1; s < MULT_LATENCY; s++) begin
                tag_valid_r[s] <= tag_valid_r[s-1];
                tag_id_r[s]    <= tag_id_r[s-1];
            end
        end
    end

    assign push_s      = tag_valid_r[MULT_LATENCY-1];
    assign push_data_s = {tag_id_r[MULT_LATENCY-1], mult_C};

    mult_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (FIFO_W)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .count     (fifo_count_s)
    );

    assign {resp_id, resp_C} = fifo_head_s;
    assign idle = (in_flight_s == '0) && (fifo_count_s == '0);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_scheduler
// Self-checking bench for mult_rr_scheduler (N=4, MULT_LATENCY=1, RES_DEPTH=2).
// Provides a behavioural registered multiplier, a queue-based reference model
// (outstanding ops with availability cycle, rr pointer, issue count), a vector
// table of known products, and directed corner sequences plus random traffic.
// -----------------------------------------------------------------------------
module tb_mult_rr_scheduler;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 1;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [8*N-1:0]   req_A;
    logic [8*N-1:0]   req_B;
    logic [N-1:0]     req_A_sign;
    logic [N-1:0]     req_B_sign;
    logic [7:0]       mult_A;
    logic [7:0]       mult_B;
    logic             mult_A_sign;
    logic             mult_B_sign;
    logic             mult_HALF_0;
    logic [15:0]      mult_C;
    logic             resp_valid;
    logic             resp_ready;
    logic [ID_W-1:0]  resp_id;
    logic [15:0]      resp_C;
    logic             idle;
    logic [31:0]      ops_count;

    mult_rr_scheduler #(
        .N(N), .ID_W(ID_W), .MULT_LATENCY(LAT), .RES_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B),
        .req_A_sign(req_A_sign), .req_B_sign(req_B_sign),
        .mult_A(mult_A), .mult_B(mult_B),
        .mult_A_sign(mult_A_sign), .mult_B_sign(mult_B_sign),
        .mult_HALF_0(mult_HALF_0), .mult_C(mult_C),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_C(resp_C),
        .idle(idle), .ops_count(ops_count)
    );

    typedef struct {
        int          id;
        logic [15:0] c;
        int          avail;
    } exp_t;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        as;
        logic        bs;
        logic [15:0] exp_c;
    } vec_t;

    int          n_pass;
    int          n_total;
    int          cyc;
    exp_t        q[$];
    int          ptr_m;
    int          ops_m;
    vec_t        vecs [6];
    logic [N-1:0]    smp_ready;
    logic            smp_valid;
    logic [ID_W-1:0] smp_id;
    logic [15:0]     smp_c;

    // Product of sign-extended 9-bit operands, truncated to 16 bits.
    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                             input logic as, input logic bs);
        int av;
        int bv;
        av = (as && a[7]) ? int'(a) - 256 : int'(a);
        bv = (bs && b[7]) ? int'(b) - 256 : int'(b);
        return 16'(av * bv);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External multiplier: one register stage.
    always @(posedge clk) mult_C <= ref_prod(mult_A, mult_B, mult_A_sign, mult_B_sign);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic as, input logic bs);
        req_A[id*8 +: 8] = a;
        req_B[id*8 +: 8] = b;
        req_A_sign[id]   = as;
        req_B_sign[id]   = bs;
    endtask

    task automatic model_reset();
        q.delete();
        ptr_m = 0;
        ops_m = 0;
    endtask

    // One cycle: compare against the model at negedge, advance the model,
    // then return at posedge+1 so the caller can drive the next inputs.
    task automatic step_check();
        int          grant;
        logic        exp_v;
        logic        pop_now;
        logic        credit;
        logic [N-1:0] exp_ready;
        logic [17:0] exp_mult;
        exp_t        e;
        @(negedge clk);
        smp_ready = req_ready;
        smp_valid = resp_valid;
        smp_id    = resp_id;
        smp_c     = resp_C;
        exp_v   = (q.size() != 0) && (q[0].avail <= cyc);
        pop_now = exp_v && resp_ready;
        credit  = (q.size() - (pop_now ? 1 : 0)) < DEPTH;
        grant   = -1;
        if (credit) begin
            for (int k = 0; k < N; k++) begin
                if (grant < 0 && req_valid[(ptr_m + k) % N]) grant = (ptr_m + k) % N;
            end
        end
        exp_ready = '0;
        exp_mult  = '0;
        if (grant >= 0) begin
            exp_ready[grant] = 1'b1;
            exp_mult = {req_A[grant*8 +: 8], req_B[grant*8 +: 8], req_A_sign[grant], req_B_sign[grant]};
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mult_operands", 32'({mult_A, mult_B, mult_A_sign, mult_B_sign}), 32'(exp_mult));
        check("resp_valid", 32'(resp_valid), 32'(exp_v));
        if (exp_v) begin
            check("resp_id", 32'(resp_id), 32'(q[0].id));
            check("resp_C", 32'(resp_C), 32'(q[0].c));
        end
        check("idle", 32'(idle), 32'(q.size() == 0));
        check("ops_count", ops_count, 32'(ops_m));
        check("push_when_full",
              32'(u_dut.push_s && (u_dut.fifo_count_s == 2'(DEPTH)) && !u_dut.pop_s), 32'd0);
        if (pop_now) void'(q.pop_front());
        if (grant >= 0) begin
            e.id    = grant;
            e.c     = ref_prod(req_A[grant*8 +: 8], req_B[grant*8 +: 8], req_A_sign[grant], req_B_sign[grant]);
            e.avail = cyc + LAT + 1;
            q.push_back(e);
            ptr_m = (grant + 1) % N;
            ops_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) step_check();
        step_check();
        check("drain_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        int hs;
        int seen;
        n_pass = 0; n_total = 0; cyc = 0;
        model_reset();
        vecs[0] = '{0, 8'hFF, 8'h02, 1'b1, 1'b1, 16'hFFFE};
        vecs[1] = '{2, 8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
        vecs[2] = '{3, 8'h80, 8'h80, 1'b1, 1'b0, 16'hC000};
        vecs[3] = '{1, 8'h7F, 8'h81, 1'b1, 1'b1, 16'hC0FF};
        vecs[4] = '{1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFF01};
        vecs[5] = '{0, 8'h00, 8'h55, 1'b1, 1'b1, 16'h0000};

        // Reset state, with requests pending while reset is held.
        reset = 1'b0; req_valid = '1; req_A = '0; req_B = '0;
        req_A_sign = '0; req_B_sign = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_C", 32'(resp_C), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ops_count", ops_count, 32'd0);
        check("half0", 32'(mult_HALF_0), 32'd0);
        req_valid = '0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // All requesters streaming: 0,1,2,3,0,1,2,3.
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 8'h10 + 8'(i), 8'hA0 + 8'(3*i), 1'(i % 2), 1'(i / 2));
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            step_check();
            check("rr_grant", 32'(smp_ready), 32'd1 << (c % N));
        end
        check("rr_ops_count", ops_count, 32'd8);
        drain();

        // Known products from the vector table, with latency check.
        for (int v = 0; v < 6; v++) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].as, vecs[v].bs);
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            resp_ready = 1'b1;
            step_check();
            check("vec_grant", 32'(smp_ready), 32'd1 << vecs[v].id);
            req_valid = '0;
            step_check();
            check("vec_early_valid", 32'(smp_valid), 32'd0);
            step_check();
            check("vec_valid", 32'(smp_valid), 32'd1);
            check("vec_id", 32'(smp_id), 32'(vecs[v].id));
            check("vec_C", 32'(smp_c), 32'(vecs[v].exp_c));
        end
        drain();

        // Backpressure: port1 streams with resp_ready low, then resumes.
        resp_ready = 1'b0;
        set_op(1, 8'h11, 8'h22, 1'b0, 1'b0);
        req_valid = 4'b0010;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            step_check();
            if (smp_ready[1]) begin
                hs++;
                set_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        check("bp_handshakes", 32'(hs), 32'd2);
        check("bp_stalled_ready", 32'(smp_ready), 32'd0);
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step_check();
            if (c == 0) begin
                check("bp_resume_valid", 32'(smp_valid), 32'd1);
                check("bp_resume_id", 32'(smp_id), 32'd1);
            end
            if (smp_ready[1]) set_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // Pointer at 2: port3 before port1; then a lone requester every cycle.
        set_op(1, 8'h05, 8'h07, 1'b0, 1'b0);
        set_op(3, 8'hF0, 8'h03, 1'b1, 1'b0);
        req_valid = 4'b1010;
        step_check();
        check("ptr_first", 32'(smp_ready), 32'h8);
        step_check();
        check("ptr_second", 32'(smp_ready), 32'h2);
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step_check();
            check("single_every_cycle", 32'(smp_ready), 32'h4);
        end
        drain();

        // Random traffic; requesters hold until granted, may occasionally drop.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || smp_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step_check();
        end
        drain();

        // Reset with one result in the FIFO and one in flight.
        resp_ready = 1'b0;
        set_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
        req_valid = 4'b0001;
        step_check();
        step_check();
        check("pre_reset_valid", 32'(resp_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_ops_count", ops_count, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_resp_C", 32'(resp_C), 32'd0);
        model_reset();
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step_check();
            if (smp_valid) seen++;
        end
        check("post_reset_quiet", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
